mips_control_fsm: RTL and testbench
===================================

# mips_control_fsm

Multicycle MIPS main controller that sits directly upstream of the ALU. It sequences each instruction through fetch, decode, execute, memory and writeback states, and produces the datapath mux selects and write enables. It also produces the 3-bit ALU operation code, and it consumes the ALU `zero` flag to resolve `beq`. It is a Moore FSM. An internal combinational funct decoder supplies the ALU code for R-type instructions.

## Interface
Parameters:
- none; all encodings are fixed package constants.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `opcode`  in  6  instruction[31:26], taken from the instruction register.
- `funct`  in  6  instruction[5:0].
- `alu_zero`  in  1  ALU zero flag.
- `alu_ctrl`  out  3  ALU op code:
  - and 000, or 001, add 010, xor 011, nor 100, srl 101, sub 110, slt 111.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `pc_src`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pc_en`  out  1  PC load enable, equal to pc_write | (branch & alu_zero).
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`, `mem_write`, `reg_write`  out  1 each  write enables.
- `reg_dst`  out  1  write register: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  writeback data: 0 = ALUOut, 1 = memory data.
- `instr_done`  out  1  high in the final state of every instruction.
- `illegal`  out  1  high in DECODE for an unknown opcode, and in EXEC for an unknown funct.
- `state`  out  4  current state, for debug and coverage.

## Operation
State encodings:
- FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5.
- EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.

Transitions:
- FETCH → DECODE.
- DECODE dispatches on `opcode`:
  - lw 100011 or sw 101011 → MEMADR.
  - R-type 000000 → EXEC.
  - beq 000100 → BRANCH.
  - addi 001000 → ADDIEX.
  - j 000010 → JUMP.
  - any other opcode → FETCH, with `illegal` set.
- MEMADR → MEMRD for lw, MEMWR for sw.
- MEMRD → MEMWB; EXEC → ALUWB; ADDIEX → ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP → FETCH.
- Encodings 12–15 are unreachable; if entered, go to FETCH with all enables 0.

Per-state outputs. Any signal not listed is 0, and `alu_ctrl` defaults to add:
- FETCH: ir_write=1, pc_write=1, alu_src_b=01.
- DECODE: alu_src_b=11 (precomputes the branch target).
- MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10.
- MEMRD: i_or_d=1.
- MEMWB: reg_write=1, mem_to_reg=1.
- MEMWR: i_or_d=1, mem_write=1.
- EXEC: alu_src_a=1, alu_ctrl = funct decode.
- ALUWB: reg_write=1, reg_dst=1.
- BRANCH: alu_src_a=1, alu_ctrl=sub, pc_src=01, branch=1.
- ADDIWB: reg_write=1.
- JUMP: pc_src=10, pc_write=1.

Funct decode:
- 100000 add, 100010 sub, 100100 and, 100101 or.
- 100111 nor, 100110 xor, 101010 slt, 000010 srl.
- Any other funct: alu_ctrl=add, `illegal`=1 in EXEC, and the writeback still occurs.

## Timing
- Reset: with `rst_n` low at a rising edge, `state` becomes FETCH.
  - While `rst_n` is low, `ir_write`, `mem_write`, `reg_write`, `pc_en`, `instr_done` and `illegal` are forced to 0. All other outputs show their FETCH values.
  - Reset asserted mid-instruction aborts the instruction: no write enable fires in that cycle, and the next instruction restarts at FETCH.
- All outputs are functions of `state`, plus `opcode`/`funct`, plus `rst_n`; there are no registered outputs.
  - The one exception is `pc_en` in BRANCH, which follows `alu_zero` combinationally in the same cycle.
- Cycles per instruction, counting FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- `opcode` and `funct` must be stable from DECODE through the last state, which holds because the IR is written only in FETCH.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum;
  - opcode and funct localparams;
  - the ALU op codes, shared with the ALU so both sides use one encoding.
- One sub-module, `alu_decoder`: combinational, mapping (aluop[1:0], funct) → alu_ctrl. The aluop encoding is 00 add, 01 sub, 10 funct.
- The FSM body is `mips_control_fsm`: a next-state block, a state register, and an output decode.

## Test plan
- Reset then lw (opcode 100011) → states 0,1,2,3,4. `mem_to_reg`=1 and `reg_write`=1 only in cycle 5, `instr_done`=1 there, and the next cycle is FETCH.
- R-type with funct 100010 → EXEC drives alu_ctrl=110, ALUWB drives reg_dst=1. Repeat for all 8 functs and confirm each code. Funct 000000 → alu_ctrl=010 with `illegal`=1.
- beq with alu_zero=1 in BRANCH → pc_en=1, pc_src=01. With alu_zero=0 → pc_en=0. The instruction completes in 3 cycles either way.
- sw, addi and j → mem_write only in MEMWR, reg_write only in ADDIWB, and JUMP with pc_src=10, pc_en=1. Cycle counts must be 4, 4 and 3.
- Opcode 111111 → `illegal`=1 in DECODE, return to FETCH, and no write enable fires.
- `rst_n` dropped in MEMRD → all enables are 0 during reset, and the state after release is FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct fields, ALU operation codes (also used by the ALU) and aluop selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder: (aluop, funct) -> alu_ctrl.
// funct_bad flags an unrecognised funct while aluop selects funct decode.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       funct_bad
);

    // Unknown functs fall back to add so the writeback still produces a value.
    always_comb begin
        alu_ctrl  = ALU_ADD;
        funct_bad = 1'b0;
        case (aluop)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_NOR:  alu_ctrl = ALU_NOR;
                    FN_XOR:  alu_ctrl = ALU_XOR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    FN_SRL:  alu_ctrl = ALU_SRL;
                    default: funct_bad = 1'b1;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main controller (Moore FSM). Sequences each instruction
// through fetch/decode/execute/memory/writeback and decodes datapath controls
// from the current state; only pc_en in BRANCH follows alu_zero directly.
module mips_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    output logic [2:0] alu_ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    state_t     dec_state;
    logic [1:0] aluop;
    logic       funct_bad;
    logic       pc_write, branch;
    logic       ir_w, mem_w, reg_w, done, ill;

    alu_decoder u_alu_decoder (
        .aluop     (aluop),
        .funct     (funct),
        .alu_ctrl  (alu_ctrl),
        .funct_bad (funct_bad)
    );

    // Next-state selection; encodings 12-15 fall through to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register with synchronous active-low reset to FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // While in reset the datapath sees FETCH selects, so the PC path is primed.
    assign dec_state = rst_n ? state_q : S_FETCH;

    // Per-state control decode; anything not set below stays 0 / add.
    always_comb begin
        aluop      = ALUOP_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        i_or_d     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_w       = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        done       = 1'b0;
        ill        = 1'b0;
        case (dec_state)
            S_FETCH: begin
                ir_w      = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ill = 1'b0;
                    default: begin
                        ill  = 1'b1;
                        done = 1'b1;
                    end
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: i_or_d = 1'b1;
            S_MEMWB: begin
                reg_w      = 1'b1;
                mem_to_reg = 1'b1;
                done       = 1'b1;
            end
            S_MEMWR: begin
                i_or_d = 1'b1;
                mem_w  = 1'b1;
                done   = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_FUNCT;
                ill       = funct_bad;
            end
            S_ALUWB: begin
                reg_w   = 1'b1;
                reg_dst = 1'b1;
                done    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
                done      = 1'b1;
            end
            S_ADDIWB: begin
                reg_w = 1'b1;
                done  = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                done     = 1'b1;
            end
            default: begin
                aluop = ALUOP_ADD;
            end
        endcase
    end

    assign pc_en      = rst_n & (pc_write | (branch & alu_zero));
    assign ir_write   = rst_n & ir_w;
    assign mem_write  = rst_n & mem_w;
    assign reg_write  = rst_n & reg_w;
    assign instr_done = rst_n & done;
    assign illegal    = rst_n & ill;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: walks each instruction class cycle by
// cycle and compares the full output vector against hand-written values.
module tb_mips_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;

    mips_control_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .alu_ctrl   (alu_ctrl),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: {alu_ctrl, src_a, src_b, pc_src, pc_en, i_or_d, ir_write,
    //                 mem_write, reg_write, reg_dst, mem_to_reg, done, illegal, state}
    logic [20:0] obs;
    assign obs = {alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d, ir_write,
                  mem_write, reg_write, reg_dst, mem_to_reg, instr_done, illegal, state};

    function automatic logic [20:0] mk(input logic [3:0] st, input logic [2:0] aluc,
                                       input logic a, input logic [1:0] b,
                                       input logic [1:0] pcs, input logic pcen,
                                       input logic iord, input logic irw, input logic mw,
                                       input logic rw, input logic rdst, input logic m2r,
                                       input logic dn, input logic il);
        return {aluc, a, b, pcs, pcen, iord, irw, mw, rw, rdst, m2r, dn, il, st};
    endfunction

    task automatic chk(input string tag, input logic [20:0] o, input logic [20:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Check the current cycle 1 time unit after the negedge, then advance one cycle.
    task automatic cyc(input string tag, input logic [20:0] e);
        #1;
        chk(tag, obs, e);
        @(negedge clk);
    endtask

    logic [20:0] e_fetch, e_rst, e_decode, e_dec_ill, e_memadr, e_memrd, e_memwb;
    logic [20:0] e_memwr, e_aluwb, e_br_t, e_br_f, e_addiex, e_addiwb, e_jump;
    logic [5:0]  fn_tab   [8];
    logic [2:0]  code_tab [8];

    initial begin
        //            st    aluc    a  b      pcs    pe iod irw mw rw rd m2r dn il
        e_fetch   = mk(4'd0, 3'b010, 0, 2'b01, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        e_rst     = mk(4'd0, 3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_decode  = mk(4'd1, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_dec_ill = mk(4'd1, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        e_memadr  = mk(4'd2, 3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_memrd   = mk(4'd3, 3'b010, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        e_memwb   = mk(4'd4, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        e_memwr   = mk(4'd5, 3'b010, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 0, 1, 0);
        e_aluwb   = mk(4'd7, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        e_br_t    = mk(4'd8, 3'b110, 1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        e_br_f    = mk(4'd8, 3'b110, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        e_addiex  = mk(4'd9, 3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_addiwb  = mk(4'd10, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        e_jump    = mk(4'd11, 3'b010, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 1, 0);

        fn_tab[0] = 6'b100000; code_tab[0] = 3'b010;  // add
        fn_tab[1] = 6'b100010; code_tab[1] = 3'b110;  // sub
        fn_tab[2] = 6'b100100; code_tab[2] = 3'b000;  // and
        fn_tab[3] = 6'b100101; code_tab[3] = 3'b001;  // or
        fn_tab[4] = 6'b100111; code_tab[4] = 3'b100;  // nor
        fn_tab[5] = 6'b100110; code_tab[5] = 3'b011;  // xor
        fn_tab[6] = 6'b101010; code_tab[6] = 3'b111;  // slt
        fn_tab[7] = 6'b000010; code_tab[7] = 3'b101;  // srl

        rst_n = 1'b0; opcode = 6'b0; funct = 6'b0; alu_zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cyc("reset", e_rst);
        rst_n = 1'b1;

        // lw: 5 cycles
        opcode = 6'b100011;
        cyc("lw_fetch", e_fetch);
        cyc("lw_decode", e_decode);
        cyc("lw_memadr", e_memadr);
        cyc("lw_memrd", e_memrd);
        cyc("lw_memwb", e_memwb);
        $display("[TB] lw sequence checked");

        // R-type with every supported funct: 4 cycles each
        for (int i = 0; i < 8; i++) begin
            opcode = 6'b000000;
            funct  = fn_tab[i];
            cyc("r_fetch", e_fetch);
            cyc("r_decode", e_decode);
            cyc("r_exec", mk(4'd6, code_tab[i], 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            cyc("r_aluwb", e_aluwb);
            $display("[TB] rtype funct %b alu_ctrl expected %b", fn_tab[i], code_tab[i]);
        end

        // R-type with unknown funct: add, illegal in EXEC, writeback still happens
        funct = 6'b000000;
        cyc("rbad_fetch", e_fetch);
        cyc("rbad_decode", e_decode);
        cyc("rbad_exec", mk(4'd6, 3'b010, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc("rbad_aluwb", e_aluwb);
        $display("[TB] rtype unknown funct checked");

        // beq taken
        opcode = 6'b000100;
        cyc("beq1_fetch", e_fetch);
        cyc("beq1_decode", e_decode);
        alu_zero = 1'b1;
        cyc("beq1_branch", e_br_t);
        alu_zero = 1'b0;
        $display("[TB] beq taken checked");

        // beq not taken
        cyc("beq0_fetch", e_fetch);
        cyc("beq0_decode", e_decode);
        cyc("beq0_branch", e_br_f);
        $display("[TB] beq not taken checked");

        // sw: 4 cycles
        opcode = 6'b101011;
        cyc("sw_fetch", e_fetch);
        cyc("sw_decode", e_decode);
        cyc("sw_memadr", e_memadr);
        cyc("sw_memwr", e_memwr);
        $display("[TB] sw sequence checked");

        // addi: 4 cycles
        opcode = 6'b001000;
        cyc("addi_fetch", e_fetch);
        cyc("addi_decode", e_decode);
        cyc("addi_ex", e_addiex);
        cyc("addi_wb", e_addiwb);
        $display("[TB] addi sequence checked");

        // j: 3 cycles
        opcode = 6'b000010;
        cyc("j_fetch", e_fetch);
        cyc("j_decode", e_decode);
        cyc("j_jump", e_jump);
        $display("[TB] j sequence checked");

        // illegal opcode: 2 cycles, no write enable
        opcode = 6'b111111;
        cyc("ill_fetch", e_fetch);
        cyc("ill_decode", e_dec_ill);
        $display("[TB] illegal opcode checked");

        // reset dropped in MEMRD of a lw
        opcode = 6'b100011;
        cyc("rlw_fetch", e_fetch);
        cyc("rlw_decode", e_decode);
        cyc("rlw_memadr", e_memadr);
        rst_n = 1'b0;
        #1;
        chk("rst_in_memrd", {obs[20:4], 4'h0}, {e_rst[20:4], 4'h0});
        @(negedge clk);
        cyc("rst_held", e_rst);
        rst_n = 1'b1;
        cyc("post_rst_fetch", e_fetch);
        cyc("post_rst_decode", e_decode);
        $display("[TB] reset abort checked");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
